// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART transmit buffer.
package uart_pkg;

    localparam int DEPTH_DEF      = 16;
    localparam int ADDR_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        REQUEST   = 2'b01,
        WAIT_DONE = 2'b10
    } tx_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO: storage, pointers, occupancy count and full/empty flags.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            wr_data_i,
    input  logic                  wr_en_i,
    input  logic                  rd_en_i,
    output logic [7:0]            rd_data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  drop_o
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [7:0]            mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_d;
    logic                  do_wr;
    logic                  do_rd;

    assign full_o    = (count_q == FULL_CNT);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // Full is judged on the registered count, so a same-cycle pop never frees a slot.
    assign do_wr  = wr_en_i & ~full_o;
    assign do_rd  = rd_en_i & ~empty_o;
    assign drop_o = wr_en_i & full_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// Transmit buffer: byte FIFO feeding a UART transmitter through a
// request/capture handshake, with a sticky overflow flag.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            wr_data,
    input  logic                  wr_en,
    input  logic                  ovf_clear,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    input  logic                  tx_read_data,
    input  logic                  tx_busy
);

    tx_state_e state_q;
    tx_state_e state_d;
    logic      overflow_q;
    logic      overflow_d;
    logic      drop;

    uart_byte_fifo #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .wr_data_i (wr_data),
        .wr_en_i   (wr_en),
        .rd_en_i   (tx_read_data),
        .rd_data_o (tx_data),
        .full_o    (full),
        .empty_o   (empty),
        .count_o   (count),
        .drop_o    (drop)
    );

    // A drop in the same cycle as a clear wins, so no lost byte goes unreported.
    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clear) begin
            overflow_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!empty && !tx_busy) begin
                    state_d = REQUEST;
                end
            end
            REQUEST: begin
                if (tx_read_data) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx_start = (state_q == REQUEST);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Scoreboard bench for uart_tx_buffer with a simple transmitter model.
module tb_uart_tx_buffer;

    localparam int DEPTH = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       ovf_clear;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_read_data;
    logic       tx_busy;

    int         n_vec = 0;
    int         n_err = 0;
    int         n_cap = 0;
    int         busy_cnt = 0;
    bit         auto_tx = 1'b0;
    bit         m_ovf = 1'b0;
    logic [7:0] exp_q[$];

    uart_tx_buffer #(
        .DEPTH      (16),
        .ADDR_WIDTH (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .ovf_clear    (ovf_clear),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_read_data (tx_read_data),
        .tx_busy      (tx_busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: transmitter model, scoreboard update, edge, output checks.
    task automatic cycle();
        bit full_m;
        if (auto_tx) begin
            if (tx_start) begin
                check("busy_at_req", 32'(tx_busy), 32'd0);
                check("req_nonempty", 32'(exp_q.size() != 0), 32'd1);
                tx_read_data = 1'b1;
                tx_busy      = 1'b1;
                busy_cnt     = 3;
            end else begin
                tx_read_data = 1'b0;
                if (busy_cnt > 0) busy_cnt--;
                tx_busy = (busy_cnt > 0);
            end
        end
        full_m = (exp_q.size() == DEPTH);
        if (reset) begin
            exp_q.delete();
            m_ovf = 1'b0;
        end else begin
            if (tx_read_data && exp_q.size() != 0) begin
                check("capture", 32'(tx_data), 32'(exp_q[0]));
                void'(exp_q.pop_front());
                n_cap++;
            end
            if (wr_en && full_m) m_ovf = 1'b1;
            else if (ovf_clear) m_ovf = 1'b0;
            if (wr_en && !full_m) exp_q.push_back(wr_data);
        end
        @(posedge clock);
        @(negedge clock);
        check("count", 32'(count), 32'(exp_q.size()));
        check("empty", 32'(empty), 32'(exp_q.size() == 0));
        check("full", 32'(full), 32'(exp_q.size() == DEPTH));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (exp_q.size() != 0) begin
            check("tx_data", 32'(tx_data), 32'(exp_q[0]));
        end
    endtask

    task automatic step(input bit we, input logic [7:0] d,
                        input bit rd, input bit clr);
        wr_en     = we;
        wr_data   = d;
        ovf_clear = clr;
        if (!auto_tx) tx_read_data = rd;
        cycle();
        wr_en     = 1'b0;
        ovf_clear = 1'b0;
        if (!auto_tx) tx_read_data = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic tx_manual(input bit busy);
        auto_tx      = 1'b0;
        busy_cnt     = 0;
        tx_read_data = 1'b0;
        tx_busy      = busy;
    endtask

    initial begin
        reset        = 1'b0;
        wr_data      = 8'h00;
        wr_en        = 1'b0;
        ovf_clear    = 1'b0;
        tx_read_data = 1'b0;
        tx_busy      = 1'b0;
        @(negedge clock);

        do_reset();
        check("rst_start", 32'(tx_start), 32'd0);

        // Single byte, transmitter idle
        step(1'b1, 8'h55, 1'b0, 1'b0);
        check("t1_start_e0", 32'(tx_start), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("t1_start_e1", 32'(tx_start), 32'd1);
        check("t1_data", 32'(tx_data), 32'h55);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t1_empty", 32'(empty), 32'd1);
        check("t1_start_off", 32'(tx_start), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Back-to-back burst through the transmitter model
        n_cap   = 0;
        auto_tx = 1'b1;
        for (int i = 1; i <= 3; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        repeat (30) step(1'b0, 8'h00, 1'b0, 1'b0);
        check("t2_caps", 32'(n_cap), 32'd3);
        tx_manual(1'b0);

        // Overfill with transmitter busy, then drain
        do_reset();
        tx_manual(1'b1);
        for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        check("t3_full", 32'(full), 32'd1);
        check("t3_count", 32'(count), 32'd16);
        check("t3_ovf", 32'(overflow), 32'd1);
        n_cap   = 0;
        auto_tx = 1'b1;
        repeat (150) step(1'b0, 8'h00, 1'b0, 1'b0);
        check("t3_caps", 32'(n_cap), 32'd16);
        tx_manual(1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("t3_ovf_clr", 32'(overflow), 32'd0);

        // Write and pop together while full; clear races
        do_reset();
        tx_manual(1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        check("t4_count", 32'(count), 32'd15);
        check("t4_ovf", 32'(overflow), 32'd1);
        step(1'b1, 8'hBB, 1'b0, 1'b0);
        step(1'b1, 8'hCC, 1'b0, 1'b1);
        check("t4_ovf_race", 32'(overflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("t4_ovf_clr", 32'(overflow), 32'd0);

        // Write and pop together at count 1
        do_reset();
        tx_manual(1'b1);
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        step(1'b1, 8'hC3, 1'b1, 1'b0);
        check("t5_count", 32'(count), 32'd1);
        check("t5_data", 32'(tx_data), 32'hC3);
        n_cap   = 0;
        auto_tx = 1'b1;
        repeat (10) step(1'b0, 8'h00, 1'b0, 1'b0);
        check("t5_caps", 32'(n_cap), 32'd1);
        tx_manual(1'b0);

        // Reset while requesting with bytes queued
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h41 + i), 1'b0, 1'b0);
        check("t6_req", 32'(tx_start), 32'd1);
        reset = 1'b1;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        reset = 1'b0;
        check("t6_start", 32'(tx_start), 32'd0);
        check("t6_count", 32'(count), 32'd0);
        check("t6_empty", 32'(empty), 32'd1);
        n_cap   = 0;
        auto_tx = 1'b1;
        repeat (10) step(1'b0, 8'h00, 1'b0, 1'b0);
        check("t6_caps", 32'(n_cap), 32'd0);
        tx_manual(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
